// File: rtl/sha256_mem_responder.sv
// Memory-side responder for the simplified_sha256 core: owns the message/digest RAM,
// loads a message from the host, starts the core and streams the digest back.
module sha256_mem_responder #(
    parameter int          NUM_OF_WORDS = 20,
    parameter int          DEPTH        = 64,
    parameter logic [15:0] MSG_BASE     = 16'h0000,
    parameter logic [15:0] OUT_BASE     = 16'h0020,
    parameter int          TIMEOUT      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        addr_err,
    output logic        timeout_err,
    output logic        core_start,
    output logic [15:0] core_message_addr,
    output logic [15:0] core_output_addr,
    input  logic        core_done,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_OF_WORDS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_OF_WORDS - 1);
    // timer counts WAIT_BUSY cycles from 0, so the flag lands TIMEOUT cycles after the start pulse
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 2);

    typedef enum logic [2:0] {LOAD, START, WAIT_BUSY, RUN, DRAIN_RD, DRAIN_OUT} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    k_reg, k_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          load_we, drain_rd, timeout_set;
    logic          addr_err_reg, timeout_err_reg;
    logic [31:0]   out_data_reg, mem_read_data_reg;
    logic [31:0]   mem [DEPTH];
    logic          in_range, core_we_ok;
    logic [AW-1:0] core_idx, load_idx, drain_idx;

    assign in_range   = (mem_addr[15:AW] == '0);
    assign core_idx   = mem_addr[AW-1:0];
    assign load_idx   = MSG_BASE[AW-1:0] + AW'(cnt_reg);
    assign drain_idx  = OUT_BASE[AW-1:0] + AW'(k_reg);
    assign core_we_ok = mem_we && in_range && (state_reg == WAIT_BUSY || state_reg == RUN);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        k_next      = k_reg;
        timer_next  = timer_reg;
        in_ready    = 1'b0;
        core_start  = 1'b0;
        out_valid   = 1'b0;
        load_we     = 1'b0;
        drain_rd    = 1'b0;
        timeout_set = 1'b0;
        case (state_reg)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_we = 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = START;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            START: begin
                core_start = 1'b1;
                timer_next = '0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!core_done) begin
                    state_next = RUN;
                end else if (timer_reg == TIMER_LAST) begin
                    timeout_set = 1'b1;
                    state_next  = LOAD;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            RUN: begin
                if (core_done) begin
                    k_next     = '0;
                    state_next = DRAIN_RD;
                end
            end
            DRAIN_RD: begin
                drain_rd   = 1'b1;
                state_next = DRAIN_OUT;
            end
            DRAIN_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (k_reg == 3'd7) begin
                        k_next     = '0;
                        state_next = LOAD;
                    end else begin
                        k_next     = k_reg + 3'd1;
                        state_next = DRAIN_RD;
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= LOAD;
            cnt_reg           <= '0;
            k_reg             <= '0;
            timer_reg         <= '0;
            addr_err_reg      <= 1'b0;
            timeout_err_reg   <= 1'b0;
            out_data_reg      <= '0;
            mem_read_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            k_reg     <= k_next;
            timer_reg <= timer_next;
            if (!in_range) addr_err_reg <= 1'b1;
            if (timeout_set) timeout_err_reg <= 1'b1;
            if (drain_rd) out_data_reg <= mem[drain_idx];
            mem_read_data_reg <= in_range ? mem[core_idx] : 32'h0;
        end
    end

    // Single write port; the host load takes priority over a (misbehaving) core write.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_idx] <= in_data;
        end else if (core_we_ok) begin
            mem[core_idx] <= mem_write_data;
        end
    end

    assign busy              = (state_reg != LOAD);
    assign addr_err          = addr_err_reg;
    assign timeout_err       = timeout_err_reg;
    assign out_data          = out_data_reg;
    assign mem_read_data     = mem_read_data_reg;
    assign core_message_addr = MSG_BASE;
    assign core_output_addr  = OUT_BASE;
endmodule

// File: tb/tb_sha256_mem_responder.sv
// Testbench for sha256_mem_responder: behavioural SHA-256 core on the memory port,
// digests checked against a software SHA-256 of the host stimulus.
module tb_sha256_mem_responder;
    localparam logic [15:0] MSG = 16'h0000;
    localparam logic [15:0] OUT = 16'h0020;
    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data, mem_write_data, mem_read_data;
    logic        busy, addr_err, timeout_err, core_start, core_done, mem_we;
    logic [15:0] core_message_addr, core_output_addr, mem_addr;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    sha256_mem_responder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .addr_err(addr_err), .timeout_err(timeout_err),
        .core_start(core_start), .core_message_addr(core_message_addr),
        .core_output_addr(core_output_addr), .core_done(core_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // SHA-256 of a 20-word (640-bit) message, padded to two 512-bit blocks.
    function automatic logic [255:0] sha256_640(input logic [639:0] m);
        logic [31:0] h [8];
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        logic [255:0] r;
        h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int blk = 0; blk < 2; blk++) begin
            for (int t = 0; t < 16; t++) begin
                if (blk == 0)     w[t] = m[t*32 +: 32];
                else if (t < 4)   w[t] = m[(16+t)*32 +: 32];
                else if (t == 4)  w[t] = 32'h80000000;
                else if (t == 15) w[t] = 32'd640;
                else              w[t] = 32'h0;
            end
            for (int t = 16; t < 64; t++) begin
                s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = w[t-16] + s0 + w[t-7] + s1;
            end
            a = h[0]; b = h[1]; c = h[2]; d = h[3];
            e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[t] + w[t];
                t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + t1;
                d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d;
            h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = h[j];
        return r;
    endfunction

    function automatic logic [639:0] rand_msg();
        logic [639:0] m;
        for (int i = 0; i < 20; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mem_we = 1'b0;
        mem_addr = 16'h0; mem_write_data = 32'h0; in_data = 32'h0; core_done = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_words(input logic [639:0] m, input int n, input bit expect_start);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = m[i*32 +: 32];
            n_checks++;
            if (in_ready !== 1'b1 || core_start !== 1'b0)
                $display("FAIL load_word%0d: in_ready=%b core_start=%b, want 1 and 0", i, in_ready, core_start);
            else n_pass++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (core_start !== expect_start)
            $display("FAIL start_pulse after %0d words: core_start=%b want %b", n, core_start, expect_start);
        else n_pass++;
    endtask

    task automatic core_begin();
        core_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (core_start !== 1'b0 || busy !== 1'b1)
            $display("FAIL start_width: core_start=%b busy=%b, want 0 and 1", core_start, busy);
        else n_pass++;
    endtask

    // Behavioural core: reads the message through the memory port, writes its digest back.
    task automatic core_process();
        logic [639:0] rdm;
        logic [255:0] dig;
        for (int i = 0; i < 20; i++) begin
            mem_addr = MSG + 16'(i);
            @(negedge clk);
            rdm[i*32 +: 32] = mem_read_data;
        end
        dig = sha256_640(rdm);
        for (int j = 0; j < 8; j++) begin
            mem_we = 1'b1; mem_addr = OUT + 16'(j); mem_write_data = dig[j*32 +: 32];
            @(negedge clk);
        end
        mem_we = 1'b0; mem_addr = 16'h0;
        core_done = 1'b1;
    endtask

    task automatic drain(input logic [255:0] dig_exp, input int hold_word);
        int waited;
        for (int j = 0; j < 8; j++) begin
            waited = 0;
            while (out_valid !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== dig_exp[j*32 +: 32])
                $display("FAIL digest_word%0d: valid=%b data=%h want 1 %h", j, out_valid, out_data, dig_exp[j*32 +: 32]);
            else n_pass++;
            if (j == hold_word) begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    n_checks++;
                    if (out_valid !== 1'b1 || out_data !== dig_exp[j*32 +: 32])
                        $display("FAIL backpressure c%0d: valid=%b data=%h want 1 %h", c, out_valid, out_data, dig_exp[j*32 +: 32]);
                    else n_pass++;
                end
            end
            repeat ($urandom_range(2, 0)) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (j < 7) begin
                n_checks++;
                if (out_valid !== 1'b0)
                    $display("FAIL no_duplicate word%0d: out_valid=%b want 0", j, out_valid);
                else n_pass++;
            end
        end
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL job_end: busy=%b in_ready=%b want 0 1", busy, in_ready);
        else n_pass++;
    endtask

    task automatic run_job(input logic [639:0] m, input int hold_word);
        load_words(m, 20, 1'b1);
        core_begin();
        core_process();
        drain(sha256_640(m), hold_word);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mem_we = 1'b0;
        mem_addr = 16'h0; mem_write_data = 32'h0; in_data = 32'h0; core_done = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || core_start !== 1'b0 || out_data !== 32'h0 ||
            mem_read_data !== 32'h0 || addr_err !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL reset_state: busy=%b ov=%b cs=%b od=%h rd=%h ae=%b te=%b want all 0",
                     busy, out_valid, core_start, out_data, mem_read_data, addr_err, timeout_err);
        else n_pass++;
        n_checks++;
        if (core_message_addr !== 16'h0000 || core_output_addr !== 16'h0020)
            $display("FAIL base_addrs: msg=%h out=%h want 0000 0020", core_message_addr, core_output_addr);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_job();
        logic [639:0] m;
        for (int i = 0; i < 20; i++) m[i*32 +: 32] = 32'(i);
        run_job(m, 3);
    endtask

    task automatic test_read_latency();
        logic [639:0] m;
        logic [31:0] a, b;
        m = rand_msg();
        m[5*32 +: 32] = 32'hDEADBEEF;
        m[6*32 +: 32] = 32'h600DF00D;
        a = $urandom; b = ~a;
        load_words(m, 20, 1'b1);
        core_begin();
        mem_addr = 16'd6;
        @(negedge clk);
        mem_addr = 16'd5;
        n_checks++;
        if (mem_read_data !== 32'h600DF00D) $display("FAIL latency_prev: rd=%h want 600df00d", mem_read_data);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem_read_data !== 32'hDEADBEEF) $display("FAIL latency_1cyc: rd=%h want deadbeef", mem_read_data);
        else n_pass++;
        mem_we = 1'b1; mem_addr = 16'd40; mem_write_data = a;
        @(negedge clk);
        mem_write_data = b;
        @(negedge clk);
        mem_we = 1'b0;
        n_checks++;
        if (mem_read_data !== a) $display("FAIL read_during_write: rd=%h want old %h", mem_read_data, a);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem_read_data !== b) $display("FAIL write_then_read: rd=%h want %h", mem_read_data, b);
        else n_pass++;
        core_process();
        drain(sha256_640(m), -1);
    endtask

    task automatic test_range_error();
        logic [639:0] m;
        m = rand_msg();
        load_words(m, 20, 1'b1);
        core_begin();
        @(negedge clk);
        n_checks++;
        if (addr_err !== 1'b0) $display("FAIL addr_err_pre: got %b want 0", addr_err);
        else n_pass++;
        mem_we = 1'b1; mem_addr = 16'h0040; mem_write_data = 32'h12345678;
        @(negedge clk);
        mem_we = 1'b0;
        n_checks++;
        if (addr_err !== 1'b1) $display("FAIL addr_err_set: got %b want 1", addr_err);
        else n_pass++;
        @(negedge clk);
        mem_addr = 16'h0000;
        n_checks++;
        if (mem_read_data !== 32'h0) $display("FAIL oor_read: rd=%h want 00000000", mem_read_data);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem_read_data !== m[31:0]) $display("FAIL alias_untouched: rd=%h want %h", mem_read_data, m[31:0]);
        else n_pass++;
        core_process();
        drain(sha256_640(m), -1);
        n_checks++;
        if (addr_err !== 1'b1) $display("FAIL addr_err_sticky: got %b want 1", addr_err);
        else n_pass++;
    endtask

    task automatic test_mid_load_reset();
        logic [639:0] m;
        load_words(rand_msg(), 7, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (addr_err !== 1'b0 || busy !== 1'b0) $display("FAIL reset_clears: addr_err=%b busy=%b want 0 0", addr_err, busy);
        else n_pass++;
        m = rand_msg();
        run_job(m, -1);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) run_job(rand_msg(), int'($urandom_range(7, 0)));
    endtask

    task automatic test_timeout();
        core_done = 1'b1;
        load_words(rand_msg(), 20, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (c < 4 && (timeout_err !== 1'b0 || busy !== 1'b1))
                $display("FAIL timeout_early c%0d: timeout_err=%b busy=%b want 0 1", c, timeout_err, busy);
            else if (c == 4 && (timeout_err !== 1'b1 || in_ready !== 1'b1))
                $display("FAIL timeout_flag: timeout_err=%b in_ready=%b want 1 1", timeout_err, in_ready);
            else n_pass++;
        end
        run_job(rand_msg(), -1);
        n_checks++;
        if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_err);
        else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_job();
        test_read_latency();
        test_range_error();
        test_mid_load_reset();
        test_back_to_back();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
